// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data-memory responder for the pmem_* port.
// Serves one read or byte-masked write at a time. pmem_resp is a one-cycle
// pulse LATENCY cycles after the request is first seen.
// Optional build macro: DMEM_RAND_LAT_EN adds 0..3 pseudo-random extra
// latency cycles drawn from a 16-bit LFSR.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [31:0] pmem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] pmem_rdata,
    output logic        pmem_resp
);

    localparam int         DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [4:0] LAT5  = 5'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic                    isWrite_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    accept;
    logic [DEPTH_LOG2-1:0]   reqIdx;
    logic [4:0]              extraLat;
    logic [4:0]              totalLat;
    logic [DEPTH_LOG2-1:0]   rdIdx;
    logic                    rdIsWrite;
    logic                    unusedAddrBits;

    assign accept         = (state_q == IDLE) && (pmem_read || pmem_write);
    assign reqIdx         = pmem_address[DEPTH_LOG2+1:2];
    assign unusedAddrBits = ^{pmem_address[31:DEPTH_LOG2+2], pmem_address[1:0]};
    assign totalLat       = LAT5 + extraLat;

`ifdef DMEM_RAND_LAT_EN
    logic [15:0] lfsr_q;
    logic        lfsrFb;

    assign lfsrFb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign extraLat = {3'b000, lfsr_q[1:0]};

    // Free-running Fibonacci LFSR supplying the extra latency on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsrFb};
        end
    end
`else
    assign extraLat = 5'd0;
`endif

    // State and latency-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: counter holds the number of BUSY cycles still to go
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (totalLat == 5'd1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = totalLat - 5'd2;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 5'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: response pulse follows the RESP state, read data is registered
    always_comb begin
        pmem_resp  = (state_q == RESP);
        pmem_rdata = rdata_q;
    end

    // Capture the transaction once on acceptance; later input changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            isWrite_q <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
        end else if (accept) begin
            isWrite_q <= pmem_write;
            idx_q     <= reqIdx;
            wdata_q   <= pmem_wdata;
            be_q      <= mem_byte_enable;
        end
    end

    // With a one-cycle latency RESP is entered straight from IDLE, so the
    // live request must be used because the latch is not yet loaded
    always_comb begin
        rdIdx     = idx_q;
        rdIsWrite = isWrite_q;
        if (state_q == IDLE) begin
            rdIdx     = reqIdx;
            rdIsWrite = pmem_write;
        end
    end

    // Read data is loaded on the edge entering RESP and otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if ((state_d == RESP) && (state_q != RESP) && !rdIsWrite) begin
            rdata_q <= mem_q[rdIdx];
        end
    end

    // Masked write commits on the edge leaving RESP; reset drops it
    always_ff @(posedge clk) begin
        if (!rst && (state_q == RESP) && isWrite_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
